gc_clk_config_ctrl: RTL and testbench

GC_CLK_CONFIG_CTRL -- requirements
Module: gc_clk_config_ctrl

---
 rtl/gc_pkg.sv | 21 ++
 rtl/gc_timeout_counter.sv | 32 +++
 rtl/gc_clk_config_ctrl.sv | 134 +++++++++++++
 tb/tb_gc_clk_config_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gc_pkg.sv
// Shared definitions for the clock-generator configuration controller:
// FSM state encoding, error codes and select IDs.
package gc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_WAIT_LOCK,
    ST_DONE,
    ST_ERR
  } gc_state_e;

  localparam logic [1:0] ERR_NONE         = 2'b00;
  localparam logic [1:0] ERR_ZERO_II      = 2'b01;
  localparam logic [1:0] ERR_LOCK_TIMEOUT = 2'b10;

  localparam logic [2:0] CLKGEN_SEL_ID = 3'b001;
  localparam logic [2:0] IDLE_SEL_ID   = 3'b000;

endpackage

// File: rtl/gc_timeout_counter.sv
// Lock-wait timeout counter: cleared outside the wait, counts while enabled,
// and flags the cycle on which the count reaches LOCK_TIMEOUT.
module gc_timeout_counter #(
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic conf_clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(LOCK_TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge conf_clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  // Expires in the wait cycle whose increment would bring the count to the limit.
  assign expired = enable &&
                   (({1'b0, count} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, LIMIT});

endmodule

// File: rtl/gc_clk_config_ctrl.sv
// Configuration controller: serialises a requested iteration interval onto the
// config bus as gapped beats, then waits for the clock generator to lock.
module gc_clk_config_ctrl
  import gc_pkg::*;
#(
  parameter int DATA_WIDTH                          = 8,
  parameter int ITERATION_VARIABLE_WIDTH            = 16,
  parameter int SELECT_WIDTH                        = 3,
  parameter logic [SELECT_WIDTH-1:0] CLKGEN_SEL     = CLKGEN_SEL_ID,
  parameter logic [SELECT_WIDTH-1:0] IDLE_SEL       = IDLE_SEL_ID,
  parameter int LOCK_TIMEOUT                        = 255
) (
  input  logic                                conf_clk,
  input  logic                                reset_n,
  input  logic                                req_valid,
  input  logic [ITERATION_VARIABLE_WIDTH-1:0] req_ii,
  output logic                                req_ready,
  output logic [DATA_WIDTH-1:0]               conf_bus,
  output logic [SELECT_WIDTH-1:0]             sel,
  input  logic                                locked_in,
  output logic                                busy,
  output logic                                done,
  output logic                                error,
  output logic [1:0]                          err_code,
  output logic [ITERATION_VARIABLE_WIDTH-1:0] cur_ii
);

  localparam int NUM_BEATS = ITERATION_VARIABLE_WIDTH / DATA_WIDTH;
  localparam int IDX_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

  gc_state_e                         state;
  logic [ITERATION_VARIABLE_WIDTH-1:0] shadow_ii;
  logic [IDX_W-1:0]                  beat_idx;
  logic [IDX_W-1:0]                  next_idx;
  logic [DATA_WIDTH-1:0]             ii_beats [NUM_BEATS];
  logic [DATA_WIDTH-1:0]             next_beat;
  logic                              lock_expired;

  for (genvar g = 0; g < NUM_BEATS; g++) begin : g_beat_slice
    assign ii_beats[g] = shadow_ii[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign next_idx  = beat_idx + IDX_W'(1);
  assign next_beat = ii_beats[next_idx];

  gc_timeout_counter #(
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) u_timeout (
    .conf_clk (conf_clk),
    .reset_n  (reset_n),
    .clear    (state != ST_WAIT_LOCK),
    .enable   (state == ST_WAIT_LOCK),
    .expired  (lock_expired)
  );

  // Beat outputs are loaded on the edge that enters SEND so they line up with the state.
  always_ff @(posedge conf_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      shadow_ii <= '0;
      beat_idx  <= '0;
      sel       <= IDLE_SEL;
      conf_bus  <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= ERR_NONE;
      cur_ii    <= '0;
    end else begin
      done     <= 1'b0;
      error    <= 1'b0;
      sel      <= IDLE_SEL;
      conf_bus <= '0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            shadow_ii <= req_ii;
            beat_idx  <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_ii == '0) begin
              state    <= ST_ERR;
              error    <= 1'b1;
              err_code <= ERR_ZERO_II;
            end else begin
              state    <= ST_SEND;
              err_code <= ERR_NONE;
              sel      <= CLKGEN_SEL;
              conf_bus <= req_ii[DATA_WIDTH-1:0];
            end
          end
        end
        ST_SEND: begin
          if (beat_idx == LAST_IDX) begin
            state <= ST_WAIT_LOCK;
          end else begin
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          beat_idx <= next_idx;
          state    <= ST_SEND;
          sel      <= CLKGEN_SEL;
          conf_bus <= next_beat;
        end
        // Lock is tested first so it wins over a simultaneous timeout.
        ST_WAIT_LOCK: begin
          if (locked_in) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            cur_ii <= shadow_ii;
          end else if (lock_expired) begin
            state    <= ST_ERR;
            error    <= 1'b1;
            err_code <= ERR_LOCK_TIMEOUT;
          end
        end
        ST_DONE, ST_ERR: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gc_clk_config_ctrl.sv
// Scoreboard bench for gc_clk_config_ctrl: stimulus queues expected beats and
// results, a negedge monitor pops and compares them as the DUT produces them.
module tb_gc_clk_config_ctrl;
  import gc_pkg::*;

  localparam int DW  = 8;
  localparam int IIW = 16;
  localparam int SW  = 3;
  localparam int LT  = 10;

  logic           conf_clk = 1'b0;
  logic           reset_n;
  logic           req_valid;
  logic [IIW-1:0] req_ii;
  logic           req_ready;
  logic [DW-1:0]  conf_bus;
  logic [SW-1:0]  sel;
  logic           locked_in;
  logic           busy;
  logic           done;
  logic           error;
  logic [1:0]     err_code;
  logic [IIW-1:0] cur_ii;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } beat_t;

  typedef struct {
    bit             is_done;
    logic [1:0]     code;
    logic [IIW-1:0] cur;
    int             cyc;
  } result_t;

  beat_t   beat_q[$];
  result_t res_q[$];
  beat_t   mon_beat;
  result_t mon_res;

  int             tests_run = 0;
  int             tests_failed = 0;
  int             cyc = 0;
  logic [IIW-1:0] model_cur_ii = '0;

  gc_clk_config_ctrl #(
    .DATA_WIDTH               (DW),
    .ITERATION_VARIABLE_WIDTH (IIW),
    .SELECT_WIDTH             (SW),
    .CLKGEN_SEL               (3'b001),
    .IDLE_SEL                 (3'b000),
    .LOCK_TIMEOUT             (LT)
  ) dut (
    .conf_clk  (conf_clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ii    (req_ii),
    .req_ready (req_ready),
    .conf_bus  (conf_bus),
    .sel       (sel),
    .locked_in (locked_in),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_code  (err_code),
    .cur_ii    (cur_ii)
  );

  always #5 conf_clk = ~conf_clk;

  always @(posedge conf_clk) cyc <= cyc + 1;

  function automatic void check_output(input string name, input logic [31:0] actual,
                                       input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endfunction

  // Monitor: every active sel cycle must match the next queued beat, every pulse the next result.
  always @(negedge conf_clk) begin
    if (reset_n === 1'b1) begin
      if (sel !== 3'b000) begin
        check_output("beat_sel", 32'(sel), 32'(3'b001));
        if (beat_q.size() == 0) begin
          check_output("unexpected_beat", 32'(conf_bus), 32'hFFFF_FFFF);
        end else begin
          mon_beat = beat_q.pop_front();
          check_output("beat_data", 32'(conf_bus), 32'(mon_beat.data));
          check_output("beat_cycle", cyc, mon_beat.cyc);
        end
      end else if (busy === 1'b1) begin
        check_output("idle_bus_zero", 32'(conf_bus), 32'h0);
      end
      if (done === 1'b1 || error === 1'b1) begin
        if (res_q.size() == 0) begin
          check_output("unexpected_pulse", 32'({done, error}), 32'h0);
        end else begin
          mon_res = res_q.pop_front();
          check_output("res_done", 32'(done), 32'(mon_res.is_done));
          check_output("res_error", 32'(error), 32'(!mon_res.is_done));
          check_output("res_err_code", 32'(err_code), 32'(mon_res.code));
          check_output("res_cur_ii", 32'(cur_ii), 32'(mon_res.cur));
          check_output("res_cycle", cyc, mon_res.cyc);
          check_output("res_ready_low", 32'(req_ready), 32'h0);
        end
      end
    end
  end

  // lock_at: WAIT_LOCK cycle (1-based) in which locked_in is high; 0 means never.
  task automatic apply_stimulus(input logic [IIW-1:0] ii, input int lock_at,
                                input bit hold_valid, input bit reset_in_gap);
    int             n;
    int             res_cyc;
    int             waited;
    bit             is_done;
    logic [1:0]     code;
    logic [IIW-1:0] exp_cur;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 50) begin
      @(negedge conf_clk);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      check_output("ready_wait", 32'(req_ready), 32'h1);
      return;
    end
    req_valid = 1'b1;
    req_ii    = ii;
    n         = cyc + 1;
    if (ii == '0) begin
      is_done = 1'b0;
      code    = ERR_ZERO_II;
      res_cyc = n;
    end else if (lock_at >= 1 && lock_at <= LT) begin
      is_done = 1'b1;
      code    = ERR_NONE;
      res_cyc = n + 3 + lock_at;
    end else begin
      is_done = 1'b0;
      code    = ERR_LOCK_TIMEOUT;
      res_cyc = n + 3 + LT;
    end
    exp_cur = is_done ? ii : model_cur_ii;
    if (ii != '0) begin
      beat_q.push_back('{ii[7:0], n});
      if (!reset_in_gap) beat_q.push_back('{ii[15:8], n + 2});
    end
    if (!reset_in_gap) res_q.push_back('{is_done, code, exp_cur, res_cyc});
    @(posedge conf_clk);
    #1;
    if (!hold_valid) begin
      req_valid = 1'b0;
      req_ii    = '0;
    end
    if (reset_in_gap) begin
      @(negedge conf_clk);
      check_output("busy_in_send", 32'(busy), 32'h1);
      @(negedge conf_clk);
      reset_n = 1'b0;
      #1;
      check_output("rst_sel", 32'(sel), 32'h0);
      check_output("rst_bus", 32'(conf_bus), 32'h0);
      check_output("rst_busy", 32'(busy), 32'h0);
      check_output("rst_ready", 32'(req_ready), 32'h1);
      check_output("rst_pulses", 32'({done, error}), 32'h0);
      repeat (2) @(negedge conf_clk);
      reset_n = 1'b1;
      model_cur_ii = '0;
      repeat (2) @(negedge conf_clk);
      check_output("post_rst_ready", 32'(req_ready), 32'h1);
      check_output("post_rst_cur_ii", 32'(cur_ii), 32'(model_cur_ii));
      check_output("post_rst_beats_left", beat_q.size(), 0);
      return;
    end
    while (cyc < res_cyc + 1) begin
      @(negedge conf_clk);
      if (cyc == n) begin
        check_output("busy_high", 32'(busy), 32'h1);
        check_output("ready_low", 32'(req_ready), 32'h0);
      end
      if (lock_at > 0 && cyc == n + 2 + lock_at) locked_in = 1'b1;
      if (hold_valid && cyc <= res_cyc) req_ii = 16'hF0F0 ^ 16'(cyc);
    end
    locked_in = 1'b0;
    if (is_done) model_cur_ii = ii;
    check_output("result_missing", res_q.size(), 0);
    check_output("beats_missing", beat_q.size(), 0);
    check_output("ready_after", 32'(req_ready), 32'h1);
    check_output("busy_after", 32'(busy), 32'h0);
    check_output("err_code_held", 32'(err_code), 32'(code));
    check_output("cur_ii_after", 32'(cur_ii), 32'(model_cur_ii));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d tests run", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n   = 1'b1;
    req_valid = 1'b0;
    req_ii    = '0;
    locked_in = 1'b0;
    #2 reset_n = 1'b0;
    #10;
    check_output("reset_sel", 32'(sel), 32'h0);
    check_output("reset_bus", 32'(conf_bus), 32'h0);
    check_output("reset_done", 32'(done), 32'h0);
    check_output("reset_error", 32'(error), 32'h0);
    check_output("reset_err_code", 32'(err_code), 32'h0);
    check_output("reset_cur_ii", 32'(cur_ii), 32'h0);
    check_output("reset_busy", 32'(busy), 32'h0);
    check_output("reset_ready", 32'(req_ready), 32'h1);
    repeat (2) @(negedge conf_clk);
    reset_n = 1'b1;
    @(negedge conf_clk);
    check_output("ready_after_release", 32'(req_ready), 32'h1);

    apply_stimulus(16'h0304, 5, 1'b0, 1'b0);
    apply_stimulus(16'h0000, 0, 1'b0, 1'b0);
    apply_stimulus(16'hBEEF, 0, 1'b0, 1'b0);
    apply_stimulus(16'h1122, LT, 1'b0, 1'b0);
    apply_stimulus(16'hA55A, 1, 1'b0, 1'b0);
    apply_stimulus(16'h0304, 5, 1'b0, 1'b1);
    apply_stimulus(16'h1234, 3, 1'b1, 1'b0);
    apply_stimulus(16'h5678, 2, 1'b0, 1'b0);

    repeat (3) @(negedge conf_clk);
    check_output("final_beat_queue", beat_q.size(), 0);
    check_output("final_result_queue", res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
